fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-issue instruction fetch stage in front of a registered
//            instruction ROM. Presents a byte address each cycle, pairs the
//            returned data with its address, and delivers it to IF/ID with
//            stall hold, redirect kill and NOP bubble insertion.
//            Optional performance counters are built when FETCH_PERF_CNT_EN
//            is defined; otherwise both counter outputs read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int               SIZE      = 32,
    parameter logic [SIZE-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [SIZE-1:0]  NOP_INSTR = 32'hE1A0_0000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [SIZE-1:0] redirect_pc_i,
    output logic [SIZE-1:0] rom_addr_o,
    input  logic [SIZE-1:0] rom_instr_i,
    output logic [SIZE-1:0] if_instr_o,
    output logic [SIZE-1:0] if_pc_o,
    output logic [SIZE-1:0] if_pc_plus8_o,
    output logic            if_valid_o,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     bubble_cnt_o
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // fetch_pc   : address currently presented to the ROM
    // out_pc     : address whose data is arriving on rom_instr_i
    // valid      : out_pc / its data is a real instruction
    // hold_instr : instruction captured on stall entry, since the ROM
    //              moves on to re-reading fetch_pc while decode is stalled
    logic [SIZE-1:0] fetch_pc_q,   fetch_pc_d;
    logic [SIZE-1:0] out_pc_q,     out_pc_d;
    logic            valid_q,      valid_d;
    logic [SIZE-1:0] hold_instr_q, hold_instr_d;
    state_t          state_q,      state_d;

    // The ROM is word addressed in practice; the low target bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc_i[1:0]};

    // Next-state logic: redirect beats stall; stall holds; otherwise advance.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        out_pc_d     = out_pc_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        state_d      = state_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[SIZE-1:2], 2'b00};
            valid_d    = 1'b0;
            state_d    = RUN;
        end else if (stall_i) begin
            // Capture the word on the bus only when first entering HOLD;
            // once in HOLD the ROM output belongs to fetch_pc, not out_pc.
            if (state_q == RUN) begin
                hold_instr_d = rom_instr_i;
                state_d      = HOLD;
            end
        end else begin
            // Same advance from RUN or HOLD: in HOLD the ROM has been
            // re-reading fetch_pc, so its data is valid next cycle.
            out_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + SIZE'(4);
            valid_d    = 1'b1;
            state_d    = RUN;
        end
    end

    // State registers with synchronous reset overriding stall and redirect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q   <= RESET_PC;
            out_pc_q     <= RESET_PC;
            valid_q      <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            state_q      <= RUN;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            out_pc_q     <= out_pc_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            state_q      <= state_d;
        end
    end

    // Output side: invalid slots become NOP bubbles.
    assign rom_addr_o    = fetch_pc_q;
    assign if_pc_o       = out_pc_q;
    assign if_pc_plus8_o = out_pc_q + SIZE'(8);
    assign if_valid_o    = valid_q;
    assign if_instr_o    = !valid_q          ? NOP_INSTR    :
                           (state_q == HOLD) ? hold_instr_q : rom_instr_i;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counts of delivered instructions and bubble cycles.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_q && !stall_i && !redirect_i && (fetch_cnt_q != 32'hFFFF_FFFF))
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (!valid_q && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    // Counter registers; reset clears both, which also masks reset bubbles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = 32'd0;
    assign bubble_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire
